// File: rtl/alu_reservation_station.sv
// Reservation station in front of the single-cycle ALU.
// Holds dispatched instructions until both operands are present, picks up
// missing operands from the CDB, and issues the lowest-index ready entry
// through a registered output stage (one issue per cycle, no backpressure).
module alu_reservation_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             dispatch_valid_i,
  output logic             dispatch_ready_o,
  input  logic [31:0]      dispatch_pc_i,
  input  logic [31:0]      dispatch_inst_i,
  input  logic [TAG_W-1:0] dispatch_rd_tag_i,
  input  logic             dispatch_rs1_ready_i,
  input  logic [TAG_W-1:0] dispatch_rs1_tag_i,
  input  logic [31:0]      dispatch_rs1_value_i,
  input  logic             dispatch_rs2_ready_i,
  input  logic [TAG_W-1:0] dispatch_rs2_tag_i,
  input  logic [31:0]      dispatch_rs2_value_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_value_i,
  output logic             alu_request_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      inst_o,
  output logic [31:0]      rs1_value_o,
  output logic [31:0]      rs2_value_o,
  output logic [TAG_W-1:0] rd_tag_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  // Flattened views of the per-entry registers, each element driven by one entry
  logic [NUM_ENTRIES-1:0] valid_vec;
  logic [NUM_ENTRIES-1:0] rs1_ready_vec;
  logic [NUM_ENTRIES-1:0] rs2_ready_vec;
  logic [31:0]            pc_arr        [NUM_ENTRIES];
  logic [31:0]            inst_arr      [NUM_ENTRIES];
  logic [TAG_W-1:0]       rd_tag_arr    [NUM_ENTRIES];
  logic [31:0]            rs1_value_arr [NUM_ENTRIES];
  logic [31:0]            rs2_value_arr [NUM_ENTRIES];

  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       issue_idx;
  logic                   issue_found;
  logic                   issue_fire;
  logic                   dispatch_fire;
  logic [NUM_ENTRIES-1:0] eligible;

  // Operands arriving on the CDB in the dispatch cycle are folded in directly
  logic        disp_rs1_ready;
  logic        disp_rs2_ready;
  logic [31:0] disp_rs1_value;
  logic [31:0] disp_rs2_value;

  assign eligible         = valid_vec & rs1_ready_vec & rs2_ready_vec;
  assign dispatch_ready_o = ~(&valid_vec);
  assign dispatch_fire    = dispatch_valid_i && dispatch_ready_o && !flush_i;
  assign issue_fire       = issue_found && !flush_i;

  assign disp_rs1_ready = dispatch_rs1_ready_i || (cdb_valid_i && (cdb_tag_i == dispatch_rs1_tag_i));
  assign disp_rs2_ready = dispatch_rs2_ready_i || (cdb_valid_i && (cdb_tag_i == dispatch_rs2_tag_i));
  assign disp_rs1_value = dispatch_rs1_ready_i ? dispatch_rs1_value_i : cdb_value_i;
  assign disp_rs2_value = dispatch_rs2_ready_i ? dispatch_rs2_value_i : cdb_value_i;

  // Lowest-index free slot and lowest-index eligible slot (descending scan so low wins)
  always_comb begin
    free_idx    = '0;
    issue_idx   = '0;
    issue_found = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_idx = IDX_W'(i);
      end
      if (eligible[i]) begin
        issue_idx   = IDX_W'(i);
        issue_found = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      logic             valid_reg;
      logic [31:0]      pc_reg;
      logic [31:0]      inst_reg;
      logic [TAG_W-1:0] rd_tag_reg;
      logic             rs1_ready_reg;
      logic [TAG_W-1:0] rs1_tag_reg;
      logic [31:0]      rs1_value_reg;
      logic             rs2_ready_reg;
      logic [TAG_W-1:0] rs2_tag_reg;
      logic [31:0]      rs2_value_reg;
      logic             rs1_hit;
      logic             rs2_hit;
      logic             is_issued;
      logic             is_target;

      assign rs1_hit   = cdb_valid_i && !rs1_ready_reg && (cdb_tag_i == rs1_tag_reg);
      assign rs2_hit   = cdb_valid_i && !rs2_ready_reg && (cdb_tag_i == rs2_tag_reg);
      assign is_issued = issue_fire && (issue_idx == IDX_W'(gi));
      assign is_target = dispatch_fire && (free_idx == IDX_W'(gi));

      // Entry update: flush > issue > dispatch write > CDB snoop
      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          valid_reg     <= 1'b0;
          pc_reg        <= '0;
          inst_reg      <= '0;
          rd_tag_reg    <= '0;
          rs1_ready_reg <= 1'b0;
          rs1_tag_reg   <= '0;
          rs1_value_reg <= '0;
          rs2_ready_reg <= 1'b0;
          rs2_tag_reg   <= '0;
          rs2_value_reg <= '0;
        end else if (flush_i) begin
          valid_reg <= 1'b0;
        end else if (is_issued) begin
          valid_reg <= 1'b0;
        end else if (is_target) begin
          valid_reg     <= 1'b1;
          pc_reg        <= dispatch_pc_i;
          inst_reg      <= dispatch_inst_i;
          rd_tag_reg    <= dispatch_rd_tag_i;
          rs1_ready_reg <= disp_rs1_ready;
          rs1_tag_reg   <= dispatch_rs1_tag_i;
          rs1_value_reg <= disp_rs1_value;
          rs2_ready_reg <= disp_rs2_ready;
          rs2_tag_reg   <= dispatch_rs2_tag_i;
          rs2_value_reg <= disp_rs2_value;
        end else if (valid_reg) begin
          if (rs1_hit) begin
            rs1_ready_reg <= 1'b1;
            rs1_value_reg <= cdb_value_i;
          end
          if (rs2_hit) begin
            rs2_ready_reg <= 1'b1;
            rs2_value_reg <= cdb_value_i;
          end
        end
      end

      assign valid_vec[gi]     = valid_reg;
      assign rs1_ready_vec[gi] = rs1_ready_reg;
      assign rs2_ready_vec[gi] = rs2_ready_reg;
      assign pc_arr[gi]        = pc_reg;
      assign inst_arr[gi]      = inst_reg;
      assign rd_tag_arr[gi]    = rd_tag_reg;
      assign rs1_value_arr[gi] = rs1_value_reg;
      assign rs2_value_arr[gi] = rs2_value_reg;
    end
  endgenerate

  // Registered issue stage; data outputs hold when nothing issues or on flush
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      alu_request_o <= 1'b0;
      pc_o          <= '0;
      inst_o        <= '0;
      rs1_value_o   <= '0;
      rs2_value_o   <= '0;
      rd_tag_o      <= '0;
    end else if (flush_i) begin
      alu_request_o <= 1'b0;
    end else begin
      alu_request_o <= issue_found;
      if (issue_found) begin
        pc_o        <= pc_arr[issue_idx];
        inst_o      <= inst_arr[issue_idx];
        rs1_value_o <= rs1_value_arr[issue_idx];
        rs2_value_o <= rs2_value_arr[issue_idx];
        rd_tag_o    <= rd_tag_arr[issue_idx];
      end
    end
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Reservation station directly upstream of the single-cycle arithmetic unit. It buffers dispatched ALU instructions until both source operands are available, snoops the common data bus (CDB) for missing operands, and issues one ready instruction per cycle. Issued instructions go to the arithmetic unit as pc/inst/rs1/rs2 values plus a request strobe. The destination tag is forwarded alongside for writeback.

Parameters:
NUM_ENTRIES, 4, number of buffer slots (power of two, 2..16)
TAG_W, 4, width of the ROB/physical destination and source tags

Ports:
clk_i  input  1  clock, rising edge
reset_i  input  1  asynchronous reset, active-low
flush_i  input  1  synchronous squash of all entries
dispatch_valid_i  input  1  dispatch request
dispatch_ready_o  output  1  at least one free slot
dispatch_pc_i  input  32  instruction PC
dispatch_inst_i  input  32  raw instruction word
dispatch_rd_tag_i  input  TAG_W  destination tag
dispatch_rs1_ready_i  input  1  rs1 value valid
dispatch_rs1_tag_i  input  TAG_W  producer tag of rs1
dispatch_rs1_value_i  input  32  rs1 value if ready
dispatch_rs2_ready_i  input  1  rs2 value valid
dispatch_rs2_tag_i  input  TAG_W  producer tag of rs2
dispatch_rs2_value_i  input  32  rs2 value if ready
cdb_valid_i  input  1  CDB broadcast valid
cdb_tag_i  input  TAG_W  broadcast tag
cdb_value_i  input  32  broadcast value
alu_request_o  output  1  issue strobe to arithmetic unit
pc_o  output  32  issued PC
inst_o  output  32  issued instruction
rs1_value_o  output  32  issued rs1 operand
rs2_value_o  output  32  issued rs2 operand
rd_tag_o  output  TAG_W  issued destination tag

Behaviour:
- Reset (reset_i low, async): all entry valid bits clear; alu_request_o=0; pc_o, inst_o, rs1_value_o, rs2_value_o and rd_tag_o=0. dispatch_ready_o=1 once entries are clear.
- Entry state: valid, pc, inst, rd_tag, plus per source: ready, tag and value.
- dispatch_ready_o is combinational from the registered valid bits: it is 1 iff any entry is invalid at the start of the cycle. A slot freed by issue in the current cycle is not visible until the next cycle.
- Dispatch accepted when dispatch_valid_i && dispatch_ready_o && !flush_i. Data is written into the lowest-index free entry at the clock edge. A dispatch while not ready is ignored; there is no internal queue.
- CDB snoop, every cycle: for each valid entry and each source with ready=0 and tag==cdb_tag_i while cdb_valid_i=1, capture cdb_value_i and set ready at the edge.
- Dispatch bypass: if a dispatched source is not ready and cdb_valid_i with a matching tag occurs in the same cycle, the entry is written with the CDB value and ready=1.
- Selection: an entry is eligible iff valid && rs1 ready && rs2 ready, using registered state. Operands captured from the CDB this cycle make the entry eligible next cycle. Among eligible entries, the lowest index wins.
- Issue is registered, 1-cycle latency. At the edge, the winner's fields load into pc_o, inst_o, rs1_value_o, rs2_value_o and rd_tag_o, alu_request_o goes to 1, and the winner's valid bit clears.
  - If no entry is eligible, alu_request_o goes to 0 and the data outputs hold their last values.
- There is no backpressure from the arithmetic unit; at most one issue per cycle.
- Dispatch into slot k and issue from slot j≠k in the same cycle are both permitted. Dispatch never targets the slot being issued, because the freed slot is not yet visible.
- flush_i: at the edge, all valid bits clear, alu_request_o goes to 0, and any dispatch or issue in that cycle is dropped. Data outputs hold their values.
- Full condition: with all NUM_ENTRIES valid, dispatch_ready_o=0 until the cycle after an issue.
- Tag 0 has no special meaning. Ready sources ignore the CDB.

Test Plan:
- Dispatch addi with both sources ready (pc=0x100, rs1=5), tag 3 -> next cycle alu_request_o=1, pc_o=0x100, rs1_value_o=5, rd_tag_o=3; the following cycle alu_request_o=0.
- Dispatch with rs2 waiting on tag 7, then CDB tag 7 value 0xDEAD two cycles later -> issue occurs the cycle after the CDB broadcast, with rs2_value_o=0xDEAD.
- Dispatch with rs1 waiting on tag 2 while CDB broadcasts tag 2 value 9 in the same cycle -> entry issues next cycle with rs1_value_o=9.
- Fill all 4 entries with unready operands -> dispatch_ready_o=0 and a 5th dispatch is ignored. Broadcast one tag -> one issue; dispatch_ready_o=1 the cycle after the issue.
- Entries 1 and 3 become ready in the same cycle -> entry 1 issues first, entry 3 the next cycle.
- 3 entries valid; assert flush_i with a concurrent dispatch -> all entries gone, no alu_request_o afterwards even on a matching CDB. Also assert reset_i low mid-issue -> alu_request_o drops immediately.
